// File: rtl/uart_ahb_master_if.sv
// AHB-Lite signal bundle between a single-word initiator and the bus matrix.
interface uart_ahb_master_if;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   modport master (
      output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/uart_ahb_master.sv
// UART command-stream to AHB-Lite bridge. Receives framed 'W'/'R' commands
// (cmd, 4 address bytes, 4 data bytes for writes, all MSB first), issues one
// single-word AHB transfer and streams the response bytes into the tx FIFO.
module uart_ahb_master #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   input  logic                     rx_valid,
   input  logic [7:0]               rx_data,
   input  logic                     tx_full,
   output logic                     tx_wr,
   output logic [7:0]               tx_data,
   output logic                     busy,
   uart_ahb_master_if.master        ahb
);

   localparam logic [7:0]  CMD_W    = 8'h57;
   localparam logic [7:0]  CMD_R    = 8'h52;
   localparam logic [7:0]  RSP_OK   = 8'h4B;
   localparam logic [7:0]  RSP_ERR  = 8'h45;
   localparam logic [1:0]  TR_IDLE  = 2'b00;
   localparam logic [1:0]  TR_NSEQ  = 2'b10;
   localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      IDLE, GET_ADDR, GET_DATA, AHB_ADDR, AHB_DATA, RESP
   } state_t;

   state_t      state_q;
   logic        dir_q;      // 1 = write
   logic        err_q;
   logic        done_q;     // last response byte already issued
   logic        tx_wr_q;
   logic [7:0]  tx_data_q;
   logic [1:0]  cnt_q;      // frame byte counter, wraps after 4
   logic [1:0]  rcnt_q;     // response byte counter, wraps after 4
   logic [1:0]  htrans_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] resp_q;
   logic [31:0] to_q;

   logic [31:0] addr_d;
   logic [31:0] wdata_d;
   logic [31:0] to_d;
   logic [7:0]  first_byte_d;
   logic [7:0]  resp_byte_d;

   // Next-value helpers: byte shifts, timeout increment and response byte selection.
   always_comb begin
      addr_d       = {addr_q[23:0], rx_data};
      wdata_d      = {wdata_q[23:0], rx_data};
      to_d         = to_q + 32'd1;
      first_byte_d = ahb.HRESP ? RSP_ERR : (dir_q ? RSP_OK : ahb.HRDATA[31:24]);
      resp_byte_d  = err_q ? RSP_ERR : (dir_q ? RSP_OK : resp_q[31:24]);
   end

   // Command parser, AHB sequencer and response streamer with registered outputs.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q   <= IDLE;
         dir_q     <= 1'b0;
         err_q     <= 1'b0;
         done_q    <= 1'b0;
         tx_wr_q   <= 1'b0;
         tx_data_q <= 8'h00;
         cnt_q     <= 2'd0;
         rcnt_q    <= 2'd0;
         htrans_q  <= TR_IDLE;
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         resp_q    <= 32'h0;
         to_q      <= 32'h0;
      end else begin
         tx_wr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rx_valid && (rx_data == CMD_W || rx_data == CMD_R)) begin
                  dir_q   <= (rx_data == CMD_W);
                  cnt_q   <= 2'd0;
                  to_q    <= 32'h0;
                  state_q <= GET_ADDR;
               end
            end
            GET_ADDR: begin
               if (rx_valid) begin
                  addr_q <= addr_d;
                  cnt_q  <= cnt_q + 2'd1;
                  to_q   <= 32'h0;
                  if (cnt_q == 2'd3) begin
                     if (dir_q) begin
                        state_q <= GET_DATA;
                     end else begin
                        state_q  <= AHB_ADDR;
                        htrans_q <= TR_NSEQ;
                     end
                  end
               end else if (to_d == TO_LIMIT) begin
                  to_q    <= 32'h0;
                  state_q <= IDLE;
               end else begin
                  to_q <= to_d;
               end
            end
            GET_DATA: begin
               if (rx_valid) begin
                  wdata_q <= wdata_d;
                  cnt_q   <= cnt_q + 2'd1;
                  to_q    <= 32'h0;
                  if (cnt_q == 2'd3) begin
                     state_q  <= AHB_ADDR;
                     htrans_q <= TR_NSEQ;
                  end
               end else if (to_d == TO_LIMIT) begin
                  to_q    <= 32'h0;
                  state_q <= IDLE;
               end else begin
                  to_q <= to_d;
               end
            end
            AHB_ADDR: begin
               // Address, direction and NONSEQ stay put until the slave accepts.
               if (ahb.HREADY) begin
                  htrans_q <= TR_IDLE;
                  state_q  <= AHB_DATA;
               end
            end
            AHB_DATA: begin
               if (ahb.HREADY) begin
                  err_q   <= ahb.HRESP;
                  state_q <= RESP;
                  // First response byte goes out on the completion edge to save a cycle.
                  if (!tx_full) begin
                     tx_wr_q   <= 1'b1;
                     tx_data_q <= first_byte_d;
                     resp_q    <= {ahb.HRDATA[23:0], 8'h00};
                     rcnt_q    <= 2'd1;
                     done_q    <= ahb.HRESP | dir_q;
                  end else begin
                     resp_q <= ahb.HRDATA;
                     rcnt_q <= 2'd0;
                     done_q <= 1'b0;
                  end
               end
            end
            RESP: begin
               if (done_q) begin
                  state_q <= IDLE;
               end else if (!tx_full) begin
                  tx_wr_q   <= 1'b1;
                  tx_data_q <= resp_byte_d;
                  resp_q    <= {resp_q[23:0], 8'h00};
                  rcnt_q    <= rcnt_q + 2'd1;
                  done_q    <= err_q | dir_q | (rcnt_q == 2'd3);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign tx_wr      = tx_wr_q;
   assign tx_data    = tx_data_q;
   assign busy       = (state_q != IDLE);
   assign ahb.HADDR  = {addr_q[31:2], 2'b00};
   assign ahb.HTRANS = htrans_q;
   assign ahb.HWRITE = dir_q;
   assign ahb.HSIZE  = 3'b010;
   assign ahb.HBURST = 3'b000;
   assign ahb.HWDATA = wdata_q;

endmodule

// File: tb/tb_uart_ahb_master.sv
// Directed bench for uart_ahb_master: write, stalled read, address alignment,
// error response, inter-byte timeout, tx back-pressure and async reset.
module tb_uart_ahb_master;

   logic       HCLK;
   logic       HRESETn;
   logic       rx_valid;
   logic [7:0] rx_data;
   logic       tx_full;
   logic       tx_wr;
   logic [7:0] tx_data;
   logic       busy;

   uart_ahb_master_if bus ();

   uart_ahb_master #(.TIMEOUT_CYCLES(100)) dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .tx_full  (tx_full),
      .tx_wr    (tx_wr),
      .tx_data  (tx_data),
      .busy     (busy),
      .ahb      (bus)
   );

   int total = 0;
   int bad   = 0;
   int beats = 0;
   int wr_full = 0;
   logic [7:0] txq[$];

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   // Collect tx bytes, accepted NONSEQ beats and writes issued while full.
   always @(posedge HCLK) begin
      if (HRESETn) begin
         if (tx_wr) txq.push_back(tx_data);
         if (tx_wr && tx_full) wr_full <= wr_full + 1;
         if (bus.HTRANS == 2'b10 && bus.HREADY) beats <= beats + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      for (int i = 0; i < limit; i++) begin
         if (!busy) break;
         tick();
      end
      chk(tag, {31'h0, busy}, 32'h0);
   endtask

   task automatic chk_q(input string tag, input logic [31:0] w, input int n);
      chk({tag, "_len"}, 32'(txq.size()), 32'(n));
      for (int i = 0; i < n && i < txq.size(); i++)
         chk(tag, {24'h0, txq[i]}, (n == 1) ? {24'h0, w[7:0]} : {24'h0, w[31-8*i -: 8]});
      txq.delete();
   endtask

   initial begin
      int b0;
      HRESETn    = 1'b0;
      rx_valid   = 1'b0;
      rx_data    = 8'h00;
      tx_full    = 1'b0;
      bus.HRDATA = 32'h0;
      bus.HREADY = 1'b1;
      bus.HRESP  = 1'b0;
      repeat (2) @(posedge HCLK);
      #1;
      chk("rst_tx_wr",   {31'h0, tx_wr}, 32'h0);
      chk("rst_tx_data", {24'h0, tx_data}, 32'h0);
      chk("rst_haddr",   bus.HADDR, 32'h0);
      chk("rst_htrans",  {30'h0, bus.HTRANS}, 32'h0);
      chk("rst_hwrite",  {31'h0, bus.HWRITE}, 32'h0);
      chk("rst_hwdata",  bus.HWDATA, 32'h0);
      chk("rst_busy",    {31'h0, busy}, 32'h0);
      chk("hsize",       {29'h0, bus.HSIZE}, 32'h2);
      chk("hburst",      {29'h0, bus.HBURST}, 32'h0);
      HRESETn = 1'b1;
      tick();

      // Write 0xDEADBEEF to 0x20000004, zero wait states.
      b0 = beats;
      send_byte(8'h57);
      send_word(32'h2000_0004);
      send_word(32'hDEAD_BEEF);
      chk("wr_htrans_a", {30'h0, bus.HTRANS}, 32'h2);
      chk("wr_haddr",    bus.HADDR, 32'h2000_0004);
      chk("wr_hwrite",   {31'h0, bus.HWRITE}, 32'h1);
      tick();
      chk("wr_htrans_d", {30'h0, bus.HTRANS}, 32'h0);
      chk("wr_hwdata",   bus.HWDATA, 32'hDEAD_BEEF);
      tick();
      chk("wr_tx_wr",    {31'h0, tx_wr}, 32'h1);
      chk("wr_tx_data",  {24'h0, tx_data}, 32'h4B);
      chk("wr_busy_hi",  {31'h0, busy}, 32'h1);
      tick();
      chk("wr_busy_lo",  {31'h0, busy}, 32'h0);
      chk("wr_tx_wr_lo", {31'h0, tx_wr}, 32'h0);
      chk("wr_beats",    32'(beats - b0), 32'h1);
      chk_q("wr_q", 32'h0000_004B, 1);

      // Read 0x20000008 with two address-phase wait states.
      send_byte(8'h52);
      send_byte(8'h20);
      send_byte(8'h00);
      send_byte(8'h00);
      bus.HREADY = 1'b0;
      send_byte(8'h08);
      chk("rd_haddr",    bus.HADDR, 32'h2000_0008);
      chk("rd_hwrite",   {31'h0, bus.HWRITE}, 32'h0);
      chk("rd_htrans0",  {30'h0, bus.HTRANS}, 32'h2);
      tick();
      chk("rd_htrans1",  {30'h0, bus.HTRANS}, 32'h2);
      tick();
      chk("rd_htrans2",  {30'h0, bus.HTRANS}, 32'h2);
      chk("rd_haddr2",   bus.HADDR, 32'h2000_0008);
      bus.HREADY = 1'b1;
      tick();
      chk("rd_htrans_d", {30'h0, bus.HTRANS}, 32'h0);
      bus.HRDATA = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] w;
         w = 32'h1234_5678;
         tick();
         chk("rd_tx_wr",   {31'h0, tx_wr}, 32'h1);
         chk("rd_tx_data", {24'h0, tx_data}, {24'h0, w[31-8*i -: 8]});
      end
      tick();
      chk("rd_busy_lo",  {31'h0, busy}, 32'h0);
      chk_q("rd_q", 32'h1234_5678, 4);

      // Unaligned address is forced to a word boundary.
      send_byte(8'h52);
      send_word(32'h4000_0003);
      chk("al_haddr",  bus.HADDR, 32'h4000_0000);
      chk("al_htrans", {30'h0, bus.HTRANS}, 32'h2);
      bus.HRDATA = 32'hCAFE_F00D;
      wait_idle("al_idle", 20);
      chk_q("al_q", 32'hCAFE_F00D, 4);

      // Two-cycle ERROR response on a read.
      send_byte(8'h52);
      send_word(32'h0000_0010);
      tick();
      chk("er_htrans_d", {30'h0, bus.HTRANS}, 32'h0);
      bus.HREADY = 1'b0;
      bus.HRESP  = 1'b1;
      tick();
      chk("er_tx_wr0",   {31'h0, tx_wr}, 32'h0);
      chk("er_busy",     {31'h0, busy}, 32'h1);
      bus.HREADY = 1'b1;
      tick();
      bus.HRESP = 1'b0;
      chk("er_tx_wr",    {31'h0, tx_wr}, 32'h1);
      chk("er_tx_data",  {24'h0, tx_data}, 32'h45);
      chk("er_htrans",   {30'h0, bus.HTRANS}, 32'h0);
      tick();
      chk("er_busy_lo",  {31'h0, busy}, 32'h0);
      chk_q("er_q", 32'h0000_0045, 1);

      // Junk byte ignored, then a truncated frame times out.
      b0 = beats;
      send_byte(8'h00);
      chk("junk_busy", {31'h0, busy}, 32'h0);
      send_byte(8'h52);
      send_byte(8'h11);
      send_byte(8'h22);
      repeat (99) tick();
      chk("to_busy_hi", {31'h0, busy}, 32'h1);
      tick();
      chk("to_busy_lo", {31'h0, busy}, 32'h0);
      chk("to_beats",   32'(beats - b0), 32'h0);
      chk("to_txq",     32'(txq.size()), 32'h0);
      bus.HRDATA = 32'h0BAD_CAFE;
      send_byte(8'h52);
      send_word(32'h0000_0020);
      chk("to_haddr", bus.HADDR, 32'h0000_0020);
      wait_idle("to_idle", 20);
      chk_q("to_q", 32'h0BAD_CAFE, 4);

      // tx FIFO full for 10 cycles while a read response is pending.
      bus.HRDATA = 32'h89AB_CDEF;
      send_byte(8'h52);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      tx_full = 1'b1;
      send_byte(8'h30);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("full_tx_wr", {31'h0, tx_wr}, 32'h0);
      end
      tx_full = 1'b0;
      wait_idle("full_idle", 20);
      chk_q("full_q", 32'h89AB_CDEF, 4);
      chk("full_wr_full", 32'(wr_full), 32'h0);

      // Asynchronous reset in the middle of a stalled data phase.
      send_byte(8'h57);
      send_word(32'h0000_0040);
      send_word(32'h1122_3344);
      tick();
      bus.HREADY = 1'b0;
      chk("ar_hwdata", bus.HWDATA, 32'h1122_3344);
      chk("ar_busy",   {31'h0, busy}, 32'h1);
      #3;
      HRESETn = 1'b0;
      #1;
      chk("ar_tx_wr",   {31'h0, tx_wr}, 32'h0);
      chk("ar_tx_data", {24'h0, tx_data}, 32'h0);
      chk("ar_haddr",   bus.HADDR, 32'h0);
      chk("ar_htrans",  {30'h0, bus.HTRANS}, 32'h0);
      chk("ar_hwrite",  {31'h0, bus.HWRITE}, 32'h0);
      chk("ar_hwdata",  bus.HWDATA, 32'h0);
      chk("ar_busy_lo", {31'h0, busy}, 32'h0);
      tick();
      HRESETn    = 1'b1;
      bus.HREADY = 1'b1;
      txq.delete();
      repeat (5) tick();
      chk("ar_txq",  32'(txq.size()), 32'h0);
      chk("ar_idle", {31'h0, busy}, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
